alu_arbiter_ctrl: RTL and testbench
===================================

ALU_ARBITER_CTRL -- requirements
Module: alu_arbiter_ctrl

Interface
REQ-001 Parameter FIXED_PRIO, default 0, 0 = round-robin arbitration, 1 = port 0 always wins.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 p0_valid / p1_valid  input  1  requester N has an operation pending.
REQ-005 p0_ready / p1_ready  output  1  requester N operation accepted this cycle.
REQ-006 p0_a, p0_b / p1_a, p1_b  input  2  operands A, B of requester N.
REQ-007 p0_cin / p1_cin  input  1  carry-in of requester N.
REQ-008 p0_s / p1_s  input  3  operation select of requester N.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  result consumer accepts result.
REQ-011 res_y  output  4  ALU result Y.
REQ-012 res_id  output  1  index of the requester owning res_y.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The ALU op map SHALL be: 000 A+B+Cin; 001 A-B (4-bit two's complement); 010 A&B; 011 A|B; 100 A^B; 101 ~A (2-bit, zero-extended); 110 A*B; 111 {3'b0, A>B}.
REQ-015 Operands SHALL be zero-extended to 4 bits before arithmetic; results SHALL wrap modulo 16.
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-017 In IDLE with any pN_valid high, the controller SHALL assert exactly one pN_ready combinationally, capture that port's A, B, Cin, S and its index, and go to EXEC.
REQ-018 pN_ready SHALL be low in EXEC and DONE and low for non-selected ports.
REQ-019 In EXEC, the controller SHALL register the ALU output into res_y, set res_valid, and go to DONE.
REQ-020 Latency SHALL be two cycles from the accept edge to res_valid high.
REQ-021 In DONE, res_valid, res_y, and res_id SHALL hold stable until res_ready is high; on that edge, res_valid SHALL clear and the state SHALL return to IDLE.
REQ-022 Peak throughput SHALL be one operation per three cycles.
REQ-023 Round-robin: when both ports are valid, the winner SHALL be the port not granted last; when one port is valid, it SHALL win regardless of history.
REQ-024 The last-grant register SHALL update only on accept.
REQ-025 FIXED_PRIO=1 SHALL override round-robin, and port 0 SHALL win every tie.
REQ-026 pN_valid dropping without a ready SHALL have no effect; no request SHALL be latched.
REQ-027 Operand changes after accept SHALL NOT affect the in-flight result.
REQ-028 res_ready high outside DONE SHALL be ignored.

Reset
REQ-029 rst SHALL force the IDLE state, res_valid=0, res_y=0, res_id=0, busy=0, and last-grant=1, so port 0 wins the first tie.
REQ-030 rst asserted mid-operation SHALL discard the in-flight transaction with no res_valid pulse.
REQ-031 After rst deasserts, the first accept SHALL be possible on the first clock edge.

Structure
REQ-032 The op-select encodings (3-bit constants) and the FSM state encodings SHALL live in a shared package, alu_pkg.
REQ-033 The combinational ALU SHALL be a separate sub-module, alu_core (A, B, Cin, S -> Y), instantiated once.
REQ-034 Arbitration and the FSM SHALL reside in alu_arbiter_ctrl.

Verification
REQ-035 Single op: p0 sends A=3, B=3, Cin=0, S=000 with res_ready=1 -> res_y=6, res_id=0, res_valid exactly 2 cycles after accept.
REQ-036 Op sweep: A=3, B=3, Cin=0, S=000..111 -> Y = 6, 0, 3, 3, 0, 0, 9, 0; a subtraction with A=1, B=2 -> Y=15.
REQ-037 Contention: p0 and p1 are both held valid continuously -> grants alternate 0, 1, 0, 1 after reset; with FIXED_PRIO=1 -> all grants go to 0.
REQ-038 Backpressure: res_ready=0 for 5 cycles in DONE -> res_y, res_id, and res_valid remain stable, no pN_ready asserts, and the return to IDLE occurs on the res_ready edge.
REQ-039 Reset mid-op: rst asserted in EXEC -> res_valid stays 0 and all outputs reach reset values asynchronously; a new op after release completes normally.
REQ-040 Operand change: p0 operands change the cycle after accept -> the result reflects the captured operands.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the arbitrated ALU: operand/result widths,
// op-select encodings and controller state encodings.
package alu_pkg;

    localparam int unsigned OPND_W = 2;
    localparam int unsigned RES_W  = 4;
    localparam int unsigned SEL_W  = 3;

    localparam logic [SEL_W-1:0] OP_ADD  = 3'b000;
    localparam logic [SEL_W-1:0] OP_SUB  = 3'b001;
    localparam logic [SEL_W-1:0] OP_AND  = 3'b010;
    localparam logic [SEL_W-1:0] OP_OR   = 3'b011;
    localparam logic [SEL_W-1:0] OP_XOR  = 3'b100;
    localparam logic [SEL_W-1:0] OP_NOTA = 3'b101;
    localparam logic [SEL_W-1:0] OP_MUL  = 3'b110;
    localparam logic [SEL_W-1:0] OP_GT   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 2-bit-operand ALU producing a 4-bit result that wraps modulo 16.
module alu_core
    import alu_pkg::*;
(
    input  logic [OPND_W-1:0] a,
    input  logic [OPND_W-1:0] b,
    input  logic              cin,
    input  logic [SEL_W-1:0]  s,
    output logic [RES_W-1:0]  y
);

    logic [RES_W-1:0]  a4;
    logic [RES_W-1:0]  b4;
    logic [OPND_W-1:0] a_inv;

    // Inversion kept at operand width so the upper result bits stay zero.
    assign a_inv = ~a;
    assign a4    = {2'b00, a};
    assign b4    = {2'b00, b};

    always_comb begin
        y = '0;
        case (s)
            OP_ADD:  y = a4 + b4 + {3'b000, cin};
            OP_SUB:  y = a4 - b4;
            OP_AND:  y = a4 & b4;
            OP_OR:   y = a4 | b4;
            OP_XOR:  y = a4 ^ b4;
            OP_NOTA: y = {2'b00, a_inv};
            OP_MUL:  y = a4 * b4;
            OP_GT:   y = {3'b000, (a > b)};
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter_ctrl.sv
// Two-requester front end for a shared ALU: arbitrates, captures the winning
// operation, executes it and holds the result until the consumer takes it.
module alu_arbiter_ctrl
    import alu_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_valid,
    input  logic [OPND_W-1:0] p0_a,
    input  logic [OPND_W-1:0] p0_b,
    input  logic              p0_cin,
    input  logic [SEL_W-1:0]  p0_s,
    output logic              p0_ready,
    input  logic              p1_valid,
    input  logic [OPND_W-1:0] p1_a,
    input  logic [OPND_W-1:0] p1_b,
    input  logic              p1_cin,
    input  logic [SEL_W-1:0]  p1_s,
    output logic              p1_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_y,
    output logic              res_id,
    output logic              busy
);

    state_e            state;
    state_e            next_state;
    logic              accept;
    logic              grant;
    logic              load_res;
    logic              clr_res;
    logic              last_grant;
    logic [OPND_W-1:0] op_a;
    logic [OPND_W-1:0] op_b;
    logic              op_cin;
    logic [SEL_W-1:0]  op_s;
    logic              op_id;
    logic [RES_W-1:0]  alu_y;

    alu_core u_alu (
        .a   (op_a),
        .b   (op_b),
        .cin (op_cin),
        .s   (op_s),
        .y   (alu_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Arbitration and sequencing; the ready handshake is combinational in IDLE.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        grant      = 1'b0;
        load_res   = 1'b0;
        clr_res    = 1'b0;
        p0_ready   = 1'b0;
        p1_ready   = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst && (p0_valid || p1_valid)) begin
                    accept = 1'b1;
                    if (p0_valid && p1_valid) grant = FIXED_PRIO ? 1'b0 : ~last_grant;
                    else                      grant = p1_valid;
                    p0_ready   = ~grant;
                    p1_ready   = grant;
                    next_state = EXEC;
                end
            end
            EXEC: begin
                load_res   = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    clr_res    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Operation capture, grant history and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            op_a       <= '0;
            op_b       <= '0;
            op_cin     <= 1'b0;
            op_s       <= '0;
            op_id      <= 1'b0;
            res_valid  <= 1'b0;
            res_y      <= '0;
            res_id     <= 1'b0;
        end else begin
            if (accept) begin
                last_grant <= grant;
                op_id      <= grant;
                op_a       <= grant ? p1_a   : p0_a;
                op_b       <= grant ? p1_b   : p0_b;
                op_cin     <= grant ? p1_cin : p0_cin;
                op_s       <= grant ? p1_s   : p0_s;
            end
            if (load_res) begin
                res_y     <= alu_y;
                res_id    <= op_id;
                res_valid <= 1'b1;
            end else if (clr_res) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter_ctrl.sv
// Bench for alu_arbiter_ctrl: round-robin and fixed-priority instances share
// stimulus; a transaction-level model is compared every cycle.
module tb_alu_arbiter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       p0_valid, p1_valid, p0_cin, p1_cin, res_ready;
    logic [1:0] p0_a, p0_b, p1_a, p1_b;
    logic [2:0] p0_s, p1_s;

    logic [1:0] o_p0r, o_p1r, o_rv, o_rid, o_busy;
    logic [3:0] o_y [2];

    int n_pass  = 0;
    int n_total = 0;

    int m_busy [2];
    int m_age  [2];
    int m_pend [2];
    int m_pid  [2];
    int m_ry   [2];
    int m_rid  [2];
    int m_last [2];

    int done_q0 [$];
    int done_q1 [$];

    always #5 clk = ~clk;

    alu_arbiter_ctrl #(.FIXED_PRIO(1'b0)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_a(p0_a), .p0_b(p0_b), .p0_cin(p0_cin), .p0_s(p0_s), .p0_ready(o_p0r[0]),
        .p1_valid(p1_valid), .p1_a(p1_a), .p1_b(p1_b), .p1_cin(p1_cin), .p1_s(p1_s), .p1_ready(o_p1r[0]),
        .res_valid(o_rv[0]), .res_ready(res_ready), .res_y(o_y[0]), .res_id(o_rid[0]), .busy(o_busy[0])
    );

    alu_arbiter_ctrl #(.FIXED_PRIO(1'b1)) dut_fp (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_a(p0_a), .p0_b(p0_b), .p0_cin(p0_cin), .p0_s(p0_s), .p0_ready(o_p0r[1]),
        .p1_valid(p1_valid), .p1_a(p1_a), .p1_b(p1_b), .p1_cin(p1_cin), .p1_s(p1_s), .p1_ready(o_p1r[1]),
        .res_valid(o_rv[1]), .res_ready(res_ready), .res_y(o_y[1]), .res_id(o_rid[1]), .busy(o_busy[1])
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Reference ALU written as plain integer arithmetic.
    function automatic int alu_ref(input int a, input int b, input int cin, input int s);
        case (s)
            0:       return (a + b + cin) % 16;
            1:       return (a - b + 16) % 16;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            5:       return 3 - a;
            6:       return (a * b) % 16;
            default: return (a > b) ? 1 : 0;
        endcase
    endfunction

    // Per-cycle comparison against the transaction model, then model advance.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int e0, e1, w;
            e0 = 0; e1 = 0; w = 0;
            if (rst) begin
                m_busy[d] = 0; m_age[d] = 0; m_ry[d] = 0; m_rid[d] = 0; m_last[d] = 1;
            end else if (m_busy[d] == 0 && (p0_valid || p1_valid)) begin
                if (p0_valid && p1_valid) w = (d == 1) ? 0 : 1 - m_last[d];
                else                      w = p1_valid ? 1 : 0;
                e0 = (w == 0) ? 1 : 0;
                e1 = (w == 1) ? 1 : 0;
            end
            chk($sformatf("d%0d_p0_ready", d), int'(o_p0r[d]), e0);
            chk($sformatf("d%0d_p1_ready", d), int'(o_p1r[d]), e1);
            chk($sformatf("d%0d_res_valid", d), int'(o_rv[d]), (m_busy[d] != 0 && m_age[d] >= 2) ? 1 : 0);
            chk($sformatf("d%0d_res_y", d), int'(o_y[d]), m_ry[d]);
            chk($sformatf("d%0d_res_id", d), int'(o_rid[d]), m_rid[d]);
            chk($sformatf("d%0d_busy", d), int'(o_busy[d]), m_busy[d]);
            if (o_rv[d] && res_ready) begin
                if (d == 0) done_q0.push_back(int'(o_y[d]) + 16 * int'(o_rid[d]));
                else        done_q1.push_back(int'(o_y[d]) + 16 * int'(o_rid[d]));
            end
            if (!rst) begin
                if (m_busy[d] == 0) begin
                    if (p0_valid || p1_valid) begin
                        m_busy[d] = 1;
                        m_age[d]  = 1;
                        m_pid[d]  = w;
                        m_last[d] = w;
                        m_pend[d] = (w == 1) ? alu_ref(int'(p1_a), int'(p1_b), int'(p1_cin), int'(p1_s))
                                             : alu_ref(int'(p0_a), int'(p0_b), int'(p0_cin), int'(p0_s));
                    end
                end else if (m_age[d] == 1) begin
                    m_age[d] = 2;
                    m_ry[d]  = m_pend[d];
                    m_rid[d] = m_pid[d];
                end else if (res_ready) begin
                    m_busy[d] = 0;
                end
            end
        end
    end

    task automatic set_port(input int port, input int a, input int b, input int cin, input int s);
        if (port == 0) begin
            p0_a = 2'(a); p0_b = 2'(b); p0_cin = 1'(cin); p0_s = 3'(s); p0_valid = 1'b1;
        end else begin
            p1_a = 2'(a); p1_b = 2'(b); p1_cin = 1'(cin); p1_s = 3'(s); p1_valid = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, wait for its grant, optionally scramble operands after accept, wait until idle.
    task automatic do_op(input int port, input int a, input int b, input int cin, input int s, input bit scramble);
        int k;
        set_port(port, a, b, cin, s);
        #1;
        k = 0;
        while (!(port == 1 ? o_p1r[0] : o_p0r[0]) && k < 10) begin tick(); k++; end
        if (k == 10) chk("do_op_grant_timeout", 0, 1);
        tick();
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        if (scramble) set_port(port, 0, 0, 0, 7);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        k = 0;
        while (o_busy[0] && k < 30) begin tick(); k++; end
        if (k == 30) chk("do_op_idle_timeout", 0, 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int sweep_exp [9];
        int k;
        sweep_exp = '{6, 0, 3, 3, 0, 0, 9, 0, 15};

        rst = 1'b1; res_ready = 1'b1;
        p0_valid = 1'b0; p1_valid = 1'b0;
        p0_a = '0; p0_b = '0; p0_cin = 1'b0; p0_s = '0;
        p1_a = '0; p1_b = '0; p1_cin = 1'b0; p1_s = '0;
        tick(); tick();
        chk("reset_res_valid", int'(o_rv[0]), 0);
        chk("reset_res_y", int'(o_y[0]), 0);
        chk("reset_busy", int'(o_busy[0]), 0);
        rst = 1'b0;

        // Single op with latency pinned cycle by cycle.
        set_port(0, 3, 3, 0, 0);
        #1 chk("single_p0_ready", int'(o_p0r[0]), 1);
        tick();
        p0_valid = 1'b0;
        chk("single_exec_res_valid", int'(o_rv[0]), 0);
        chk("single_exec_busy", int'(o_busy[0]), 1);
        tick();
        chk("single_res_valid", int'(o_rv[0]), 1);
        chk("single_res_y", int'(o_y[0]), 6);
        chk("single_res_id", int'(o_rid[0]), 0);
        tick();
        chk("single_back_idle", int'(o_busy[0]), 0);

        // Op sweep plus a wrapping subtraction.
        done_q0.delete();
        for (int s = 0; s < 8; s++) do_op(0, 3, 3, 0, s, 1'b0);
        do_op(0, 1, 2, 0, 1, 1'b0);
        chk("sweep_count", done_q0.size(), 9);
        for (int i = 0; i < 9 && i < done_q0.size(); i++)
            chk($sformatf("sweep_y_%0d", i), done_q0[i], sweep_exp[i]);

        // Contention straight out of reset: both ports held valid for four ops.
        rst = 1'b1;
        set_port(0, 1, 1, 0, 0);
        set_port(1, 2, 1, 0, 0);
        tick(); tick();
        done_q0.delete(); done_q1.delete();
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        p0_valid = 1'b0; p1_valid = 1'b0;
        k = 0;
        while (o_busy[0] && k < 20) begin tick(); k++; end
        if (k == 20) chk("contention_idle_timeout", 0, 1);
        chk("rr_count", done_q0.size(), 4);
        chk("fp_count", done_q1.size(), 4);
        for (int i = 0; i < 4 && i < done_q0.size(); i++)
            chk($sformatf("rr_grant_%0d", i), done_q0[i], (i % 2 == 0) ? 2 : 19);
        for (int i = 0; i < 4 && i < done_q1.size(); i++)
            chk($sformatf("fp_grant_%0d", i), done_q1[i], 2);

        // Backpressure: result held in DONE while p0 requests are refused.
        res_ready = 1'b0;
        set_port(1, 2, 3, 0, 6);
        #1 chk("bp_p1_ready", int'(o_p1r[0]), 1);
        tick();
        p1_valid = 1'b0;
        set_port(0, 1, 1, 0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_res_valid", int'(o_rv[0]), 1);
            chk("bp_res_y", int'(o_y[0]), 6);
            chk("bp_res_id", int'(o_rid[0]), 1);
            chk("bp_p0_ready", int'(o_p0r[0]), 0);
            tick();
        end
        p0_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        chk("bp_release_res_valid", int'(o_rv[0]), 0);
        chk("bp_release_busy", int'(o_busy[0]), 0);

        // Asynchronous reset while in EXEC.
        set_port(0, 3, 2, 0, 1);
        #1 chk("rmid_p0_ready", int'(o_p0r[0]), 1);
        tick();
        p0_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rmid_res_valid", int'(o_rv[0]), 0);
        chk("rmid_res_y", int'(o_y[0]), 0);
        chk("rmid_res_id", int'(o_rid[0]), 0);
        chk("rmid_busy", int'(o_busy[0]), 0);
        tick();
        rst = 1'b0;
        done_q0.delete();
        do_op(1, 3, 1, 0, 7, 1'b0);
        chk("rmid_after_count", done_q0.size(), 1);
        if (done_q0.size() > 0) chk("rmid_after_result", done_q0[0], 17);

        // Operands scrambled right after accept must not leak into the result.
        done_q0.delete();
        do_op(0, 2, 1, 1, 0, 1'b1);
        chk("opchg_count", done_q0.size(), 1);
        if (done_q0.size() > 0) chk("opchg_result", done_q0[0], 4);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
